hazard_stall_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage ARM-subset core. Sits beside the ID stage and its decoder.
- Detects RAW hazards between the ID-stage sources and the EXE/MEM destinations.
- Generates PC/IF-ID freeze, IF-ID flush and ID-EXE bubble.
- Freezes the whole pipe while the data memory is not ready, with a wait timeout and saturating performance counters.

---
 rtl/hazard_stall_ctrl_if.sv | 51 +++++
 rtl/hazard_stall_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Bundle between the pipeline datapath and the hazard/stall controller.
//   master : pipeline side; drives the ID/EXE/MEM hazard inputs and the
//            memory handshake, receives the freeze/flush/bubble controls.
//   slave  : controller side (hazard_stall_ctrl).
// Signals:
//   id_valid, id_src1, id_src2, id_use_src1, id_use_src2   ID-stage operands
//   exe_dest, exe_wb_en, exe_mem_r                         EXE destination
//   mem_dest, mem_wb_en                                    MEM destination
//   branch_taken                                           EXE taken branch
//   mem_req, mem_ready                                     data-memory handshake
//   freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe,
//   freeze_pipe                                            pipeline controls
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int REG_ADDR_W = 4
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_use_src1;
    logic                  id_use_src2;
    logic [REG_ADDR_W-1:0] exe_dest;
    logic                  exe_wb_en;
    logic                  exe_mem_r;
    logic [REG_ADDR_W-1:0] mem_dest;
    logic                  mem_wb_en;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  freeze_pc;
    logic                  freeze_if_id;
    logic                  flush_if_id;
    logic                  bubble_id_exe;
    logic                  freeze_pipe;

    modport master (
        output id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
        output exe_dest, exe_wb_en, exe_mem_r, mem_dest, mem_wb_en,
        output branch_taken, mem_req, mem_ready,
        input  freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_pipe
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use_src1, id_use_src2,
        input  exe_dest, exe_wb_en, exe_mem_r, mem_dest, mem_wb_en,
        input  branch_taken, mem_req, mem_ready,
        output freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe, freeze_pipe
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage core. Detects RAW hazards
// between ID sources and EXE/MEM destinations, generates PC/IF-ID freeze,
// IF-ID flush and ID-EXE bubble, and freezes the whole pipe while data memory
// is not ready (with a sticky wait timeout and saturating perf counters).
// Priority of the pipeline controls: memory wait > taken branch > hazard.
//
// Optional build macro HAZARD_FORWARDING_EN: hazards reduce to load-use only
// and registered forwarding selects fwd_sel1/fwd_sel2 are added
// (01 = forward from MEM, 10 = forward from WB, 00 = register file).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   pif (slave)       hazard inputs, memory handshake, pipeline controls
//   cnt_clr           synchronous clear of the performance counters
//   mem_timeout       sticky memory-wait timeout flag
//   ctrl_state        00 RUN, 01 MEM_WAIT, 10 TIMEOUT
//   stall_cycles, flush_count, mem_wait_cycles   saturating counters
//   fwd_sel1, fwd_sel2   (HAZARD_FORWARDING_EN only) forwarding selects
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int REG_ADDR_W  = 4,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    hazard_stall_ctrl_if.slave  pif,
    input  logic                cnt_clr,
    output logic                mem_timeout,
    output logic [1:0]          ctrl_state,
    output logic [CNT_W-1:0]    stall_cycles,
    output logic [CNT_W-1:0]    flush_count,
    output logic [CNT_W-1:0]    mem_wait_cycles
`ifdef HAZARD_FORWARDING_EN
    ,
    output logic [1:0]          fwd_sel1,
    output logic [1:0]          fwd_sel2
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_TIMEOUT  = 2'b10
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [WAIT_W-1:0]   wait_cnt_r, wait_cnt_nxt_s;
    logic                timeout_set_s;
    logic                mem_timeout_r;
    logic [CNT_W-1:0]    stall_cnt_r, flush_cnt_r, mwait_cnt_r;

    logic mem_wait_s;
    logic m1_exe_s, m2_exe_s, m1_mem_s, m2_mem_s;
    logic hazard_s;
    logic freeze_if_id_s, flush_s, bubble_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    assign mem_wait_s = pif.mem_req & ~pif.mem_ready;

    // Source/destination matches, qualified by source use and write-back enable.
    assign m1_exe_s = pif.id_use_src1 & (pif.id_src1 == pif.exe_dest) & pif.exe_wb_en;
    assign m2_exe_s = pif.id_use_src2 & (pif.id_src2 == pif.exe_dest) & pif.exe_wb_en;
    assign m1_mem_s = pif.id_use_src1 & (pif.id_src1 == pif.mem_dest) & pif.mem_wb_en;
    assign m2_mem_s = pif.id_use_src2 & (pif.id_src2 == pif.mem_dest) & pif.mem_wb_en;

`ifdef HAZARD_FORWARDING_EN
    // With forwarding only a load in EXE cannot supply its result in time.
    assign hazard_s = pif.id_valid & pif.exe_mem_r & (m1_exe_s | m2_exe_s);
`else
    assign hazard_s = pif.id_valid & (m1_exe_s | m2_exe_s | m1_mem_s | m2_mem_s);

    logic unused_fwd_s;
    assign unused_fwd_s = pif.exe_mem_r;
`endif

    assign freeze_if_id_s = mem_wait_s | (hazard_s & ~pif.branch_taken);
    assign flush_s        = pif.branch_taken & ~mem_wait_s;
    assign bubble_s       = (hazard_s | pif.branch_taken) & ~mem_wait_s;

    assign pif.freeze_pipe   = mem_wait_s;
    assign pif.flush_if_id   = flush_s;
    assign pif.freeze_pc     = freeze_if_id_s;
    assign pif.freeze_if_id  = freeze_if_id_s;
    assign pif.bubble_id_exe = bubble_s;

    // State register, wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            wait_cnt_r    <= wait_cnt_nxt_s;
            mem_timeout_r <= mem_timeout_r | timeout_set_s;
        end
    end

    // Memory-wait FSM next state; wait_cnt counts consecutive wait cycles.
    always_comb begin
        state_nxt_s    = state_r;
        wait_cnt_nxt_s = wait_cnt_r;
        timeout_set_s  = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (mem_wait_s) begin
                    state_nxt_s    = ST_MEM_WAIT;
                    wait_cnt_nxt_s = WAIT_W'(1);
                end else begin
                    wait_cnt_nxt_s = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_wait_s) begin
                    if (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1)) begin
                        state_nxt_s   = ST_TIMEOUT;
                        timeout_set_s = 1'b1;
                    end else begin
                        wait_cnt_nxt_s = wait_cnt_r + WAIT_W'(1);
                    end
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = '0;
                end
            end
            ST_TIMEOUT: begin
                if (mem_wait_s) begin
                    state_nxt_s = ST_TIMEOUT;
                end else begin
                    state_nxt_s    = ST_RUN;
                    wait_cnt_nxt_s = '0;
                end
            end
            default: begin
                state_nxt_s    = ST_RUN;
                wait_cnt_nxt_s = '0;
            end
        endcase
    end

    // Saturating performance counters; cnt_clr wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
            mwait_cnt_r <= '0;
        end else begin
            if (freeze_if_id_s && !mem_wait_s) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (flush_s) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
            if (mem_wait_s) begin
                mwait_cnt_r <= sat_inc(mwait_cnt_r);
            end
        end
    end

`ifdef HAZARD_FORWARDING_EN
    logic [1:0] fwd1_r, fwd2_r;

    // Forwarding selects: EXE match has priority, bubbles clear, frozen pipe holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd1_r <= 2'b00;
            fwd2_r <= 2'b00;
        end else if (mem_wait_s) begin
            fwd1_r <= fwd1_r;
            fwd2_r <= fwd2_r;
        end else if (bubble_s) begin
            fwd1_r <= 2'b00;
            fwd2_r <= 2'b00;
        end else begin
            fwd1_r <= m1_exe_s ? 2'b01 : (m1_mem_s ? 2'b10 : 2'b00);
            fwd2_r <= m2_exe_s ? 2'b01 : (m2_mem_s ? 2'b10 : 2'b00);
        end
    end

    assign fwd_sel1 = fwd1_r;
    assign fwd_sel2 = fwd2_r;
`endif

    assign mem_timeout     = mem_timeout_r;
    assign ctrl_state      = state_r;
    assign stall_cycles    = stall_cnt_r;
    assign flush_count     = flush_cnt_r;
    assign mem_wait_cycles = mwait_cnt_r;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed-vector bench for hazard_stall_ctrl (CNT_W=4, MEM_TIMEOUT=8).
// Expected values are hand-computed; build with or without
// HAZARD_FORWARDING_EN.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cnt_clr;
    logic       mem_timeout;
    logic [1:0] ctrl_state;
    logic [3:0] stall_cycles, flush_count, mem_wait_cycles;
`ifdef HAZARD_FORWARDING_EN
    logic [1:0] fwd_sel1, fwd_sel2;
`endif

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    hazard_stall_ctrl_if #(.REG_ADDR_W(4)) bus ();

    hazard_stall_ctrl #(
        .REG_ADDR_W (4),
        .CNT_W      (4),
        .MEM_TIMEOUT(8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pif            (bus.slave),
        .cnt_clr        (cnt_clr),
        .mem_timeout    (mem_timeout),
        .ctrl_state     (ctrl_state),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .mem_wait_cycles(mem_wait_cycles)
`ifdef HAZARD_FORWARDING_EN
        ,
        .fwd_sel1       (fwd_sel1),
        .fwd_sel2       (fwd_sel2)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_idle();
        bus.id_valid     = 1'b0;
        bus.id_src1      = 4'd0;
        bus.id_src2      = 4'd0;
        bus.id_use_src1  = 1'b0;
        bus.id_use_src2  = 1'b0;
        bus.exe_dest     = 4'd0;
        bus.exe_wb_en    = 1'b0;
        bus.exe_mem_r    = 1'b0;
        bus.mem_dest     = 4'd0;
        bus.mem_wb_en    = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mem_req      = 1'b0;
        bus.mem_ready    = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input logic fpc, input logic fl, input logic bub, input logic fp);
        check_val({tag, "_freeze_pc"}, 32'(bus.freeze_pc), 32'(fpc));
        check_val({tag, "_freeze_if_id"}, 32'(bus.freeze_if_id), 32'(fpc));
        check_val({tag, "_flush"}, 32'(bus.flush_if_id), 32'(fl));
        check_val({tag, "_bubble"}, 32'(bus.bubble_id_exe), 32'(bub));
        check_val({tag, "_freeze_pipe"}, 32'(bus.freeze_pipe), 32'(fp));
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic haz_off;

    initial begin
`ifdef HAZARD_FORWARDING_EN
        haz_off = 1'b0;
`else
        haz_off = 1'b1;
`endif
        set_idle();
        cnt_clr = 1'b0;
        rst = 1'b1;
        bus.mem_req = 1'b1;
        bus.mem_ready = 1'b0;

        // Reset held two cycles with memory waiting.
        tick();
        check_val("rst_state", 32'(ctrl_state), 32'd0);
        check_val("rst_stall", 32'(stall_cycles), 32'd0);
        check_val("rst_flush", 32'(flush_count), 32'd0);
        check_val("rst_mwait", 32'(mem_wait_cycles), 32'd0);
        check_val("rst_timeout", 32'(mem_timeout), 32'd0);
        check_val("rst_freeze_pipe", 32'(bus.freeze_pipe), 32'd1);
        tick();
        check_val("rst2_state", 32'(ctrl_state), 32'd0);
        check_val("rst2_mwait", 32'(mem_wait_cycles), 32'd0);
        rst = 1'b0;
        tick();
        check_val("rel_state", 32'(ctrl_state), 32'd1);
        check_val("rel_mwait", 32'(mem_wait_cycles), 32'd1);

        // Reset mid-wait aborts to RUN.
        rst = 1'b1;
        tick();
        check_val("midrst_state", 32'(ctrl_state), 32'd0);
        check_val("midrst_mwait", 32'(mem_wait_cycles), 32'd0);
        do_reset();
        settle();
        check_ctrl("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Src1 vs EXE destination.
        bus.id_valid = 1'b1; bus.id_use_src1 = 1'b1; bus.id_src1 = 4'd3;
        bus.exe_dest = 4'd3; bus.exe_wb_en = 1'b1;
        settle();
        check_ctrl("exe_haz", haz_off, 1'b0, haz_off, 1'b0);
        tick();
        if (haz_off) exp_stall++;
        check_val("exe_haz_stall", 32'(stall_cycles), 32'(exp_stall));
`ifdef HAZARD_FORWARDING_EN
        check_val("exe_haz_fwd1", 32'(fwd_sel1), 32'd1);
`endif

        // Src1 vs MEM destination.
        bus.exe_wb_en = 1'b0; bus.mem_dest = 4'd3; bus.mem_wb_en = 1'b1;
        settle();
        check_ctrl("mem_haz", haz_off, 1'b0, haz_off, 1'b0);
        tick();
        if (haz_off) exp_stall++;
        check_val("mem_haz_stall", 32'(stall_cycles), 32'(exp_stall));
`ifdef HAZARD_FORWARDING_EN
        check_val("mem_haz_fwd1", 32'(fwd_sel1), 32'd2);
`endif

        // Src2 vs MEM destination.
        bus.id_use_src1 = 1'b0; bus.id_use_src2 = 1'b1; bus.id_src2 = 4'd5; bus.mem_dest = 4'd5;
        settle();
        check_ctrl("src2_haz", haz_off, 1'b0, haz_off, 1'b0);
        tick();
        if (haz_off) exp_stall++;
        check_val("src2_haz_stall", 32'(stall_cycles), 32'(exp_stall));
`ifdef HAZARD_FORWARDING_EN
        check_val("src2_fwd1", 32'(fwd_sel1), 32'd0);
        check_val("src2_fwd2", 32'(fwd_sel2), 32'd2);
`endif

        // Matching registers but no valid instruction: no hazard.
        bus.id_valid = 1'b0;
        settle();
        check_ctrl("novalid", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        check_val("novalid_stall", 32'(stall_cycles), 32'(exp_stall));

        // Load-use: a stall in both builds.
        bus.id_valid = 1'b1; bus.id_use_src2 = 1'b0; bus.mem_wb_en = 1'b0;
        bus.id_use_src1 = 1'b1; bus.id_src1 = 4'd7; bus.exe_dest = 4'd7;
        bus.exe_wb_en = 1'b1; bus.exe_mem_r = 1'b1;
        settle();
        check_ctrl("ld_use", 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        exp_stall++;
        check_val("ld_use_stall", 32'(stall_cycles), 32'(exp_stall));
`ifdef HAZARD_FORWARDING_EN
        check_val("ld_use_fwd1", 32'(fwd_sel1), 32'd0);
`endif

        // Hazard plus taken branch: flush wins, no freeze.
        bus.branch_taken = 1'b1;
        settle();
        check_ctrl("br_haz", 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_val("br_haz_flush", 32'(flush_count), 32'd1);
        check_val("br_haz_stall", 32'(stall_cycles), 32'(exp_stall));

        // Seven wait cycles: no timeout.
        do_reset();
        bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
        settle();
        for (int i = 0; i < 7; i++) begin
            check_val("w7_freeze_pipe", 32'(bus.freeze_pipe), 32'd1);
            tick();
        end
        check_val("w7_state", 32'(ctrl_state), 32'd1);
        bus.mem_ready = 1'b1;
        settle();
        check_val("w7_rdy_freeze_pipe", 32'(bus.freeze_pipe), 32'd0);
        tick();
        check_val("w7_end_state", 32'(ctrl_state), 32'd0);
        check_val("w7_mwait", 32'(mem_wait_cycles), 32'd7);
        check_val("w7_timeout", 32'(mem_timeout), 32'd0);

        // Eight wait cycles: timeout, branch suppressed during wait.
        bus.mem_ready = 1'b0;
        settle();
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                bus.branch_taken = 1'b1;
                settle();
                check_ctrl("w8_branch", 1'b1, 1'b0, 1'b0, 1'b1);
                bus.branch_taken = 1'b0;
            end
            if (i == 7) begin
                check_val("w8_pre_state", 32'(ctrl_state), 32'd1);
                check_val("w8_pre_timeout", 32'(mem_timeout), 32'd0);
            end
            tick();
        end
        check_val("w8_state", 32'(ctrl_state), 32'd2);
        check_val("w8_timeout", 32'(mem_timeout), 32'd1);
        check_val("w8_mwait", 32'(mem_wait_cycles), 32'd15);
        tick();
        check_val("w9_state", 32'(ctrl_state), 32'd2);
        check_val("w9_mwait_sat", 32'(mem_wait_cycles), 32'd15);
        bus.mem_ready = 1'b1;
        tick();
        check_val("w8_end_state", 32'(ctrl_state), 32'd0);
        check_val("w8_end_timeout", 32'(mem_timeout), 32'd1);
        check_val("w8_end_flush", 32'(flush_count), 32'd0);
        bus.mem_req = 1'b0;
        tick();
        check_val("sticky_timeout", 32'(mem_timeout), 32'd1);
        do_reset();
        settle();
        check_val("clr_timeout", 32'(mem_timeout), 32'd0);

        // Sustained load-use hazard saturates stall_cycles, then clear.
        bus.id_valid = 1'b1; bus.id_use_src1 = 1'b1; bus.id_src1 = 4'd9;
        bus.exe_dest = 4'd9; bus.exe_wb_en = 1'b1; bus.exe_mem_r = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14) check_val("sat_stall_15", 32'(stall_cycles), 32'd15);
        end
        check_val("sat_stall_hold", 32'(stall_cycles), 32'd15);
        cnt_clr = 1'b1;
        tick();
        check_val("cnt_clr_stall", 32'(stall_cycles), 32'd0);
        cnt_clr = 1'b0;
        tick();
        check_val("post_clr_stall", 32'(stall_cycles), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
